// File: rtl/codec_seq_pkg.sv
// rtl/codec_seq_pkg.sv - shared types and defaults for the codec sample sequencer
// Purpose: state encoding of the sequencer FSM and the default sample width.
// Ports: none (package).
package codec_seq_pkg;

  localparam int DEFAULT_DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FX_SEND = 2'd1,
    FX_WAIT = 2'd2,
    WRITE   = 2'd3
  } seq_state_e;

endpackage : codec_seq_pkg

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for status reporting
// Purpose: counts single-cycle increment requests, holding at all-ones.
// Ports:
//   clk      in   1      rising-edge clock
//   reset_n  in   1      synchronous active-low reset, clears the count
//   inc      in   1      increment request
//   count    out  CNT_W  current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule : sat_counter

// File: rtl/codec_sample_sequencer.sv
// rtl/codec_sample_sequencer.sv - one-sample codec read / effect / codec write sequencer
// Purpose: captures a stereo sample from the codec, optionally routes it through the
//   effect stage (with a timeout fallback to the dry sample) and writes the result back.
// Ports:
//   CLOCK_50, reset_n                     clock, synchronous active-low reset
//   bypass                                skip effect stage (sampled at capture)
//   read_ready, readdata_left/right, read codec read side
//   write_ready, write, writedata_left/right  codec write side
//   fx_valid, fx_ready, fx_left/right     dry sample to effect stage
//   fx_out_valid, fx_out_ready, fx_out_left/right  processed sample from effect stage
//   sample_count, timeout_count           saturating status counters
//   busy                                  sequencer not idle
module codec_sample_sequencer
  import codec_seq_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int CNT_W      = 16,
  parameter int FX_TIMEOUT = 1024
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              bypass,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  input  logic              write_ready,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              fx_valid,
  input  logic              fx_ready,
  output logic [DATA_W-1:0] fx_left,
  output logic [DATA_W-1:0] fx_right,
  input  logic              fx_out_valid,
  output logic              fx_out_ready,
  input  logic [DATA_W-1:0] fx_out_left,
  input  logic [DATA_W-1:0] fx_out_right,
  output logic [CNT_W-1:0]  sample_count,
  output logic [CNT_W-1:0]  timeout_count,
  output logic              busy
);

  localparam int TMR_W = (FX_TIMEOUT > 1) ? $clog2(FX_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FX_TIMEOUT - 1);

  seq_state_e        r_state;
  seq_state_e        w_next;
  logic [DATA_W-1:0] r_sample_l;
  logic [DATA_W-1:0] r_sample_r;
  logic [DATA_W-1:0] r_wr_l;
  logic [DATA_W-1:0] r_wr_r;
  logic [TMR_W-1:0]  r_timer;

  logic w_read;
  logic w_write;
  logic w_fx_valid;
  logic w_fx_out_ready;
  logic w_timeout;

  // Handshake strobes are combinational from state so a bypassed sample is
  // read and written on consecutive cycles. They are held low during reset.
  always_comb begin
    w_next         = r_state;
    w_read         = 1'b0;
    w_write        = 1'b0;
    w_fx_valid     = 1'b0;
    w_fx_out_ready = 1'b0;
    w_timeout      = 1'b0;
    if (reset_n) begin
      case (r_state)
        IDLE: begin
          if (read_ready) begin
            w_read = 1'b1;
            w_next = bypass ? WRITE : FX_SEND;
          end
        end
        FX_SEND: begin
          w_fx_valid = 1'b1;
          // An acceptance on the last timer cycle still takes the effect path.
          if (fx_ready) begin
            w_next = FX_WAIT;
          end else if (r_timer == TMR_LAST) begin
            w_timeout = 1'b1;
            w_next    = WRITE;
          end
        end
        FX_WAIT: begin
          w_fx_out_ready = 1'b1;
          if (fx_out_valid) begin
            w_next = WRITE;
          end
        end
        WRITE: begin
          if (write_ready) begin
            w_write = 1'b1;
            w_next  = IDLE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_sample_l <= '0;
      r_sample_r <= '0;
      r_wr_l     <= '0;
      r_wr_r     <= '0;
      r_timer    <= '0;
    end else begin
      r_state <= w_next;
      // Timer runs only while offering to the effect stage; any other state rearms it.
      if (r_state == FX_SEND) begin
        r_timer <= r_timer + 1'b1;
      end else begin
        r_timer <= '0;
      end
      if (w_read) begin
        r_sample_l <= readdata_left;
        r_sample_r <= readdata_right;
        if (bypass) begin
          r_wr_l <= readdata_left;
          r_wr_r <= readdata_right;
        end
      end
      if (w_timeout) begin
        r_wr_l <= r_sample_l;
        r_wr_r <= r_sample_r;
      end
      if (w_fx_out_ready && fx_out_valid) begin
        r_wr_l <= fx_out_left;
        r_wr_r <= fx_out_right;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
    .clk     (CLOCK_50),
    .reset_n (reset_n),
    .inc     (w_write),
    .count   (sample_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
    .clk     (CLOCK_50),
    .reset_n (reset_n),
    .inc     (w_timeout),
    .count   (timeout_count)
  );

  assign read            = w_read;
  assign write           = w_write;
  assign fx_valid        = w_fx_valid;
  assign fx_out_ready    = w_fx_out_ready;
  assign fx_left         = r_sample_l;
  assign fx_right        = r_sample_r;
  assign writedata_left  = r_wr_l;
  assign writedata_right = r_wr_r;
  assign busy            = (r_state != IDLE);

endmodule : codec_sample_sequencer

// File: tb/tb_codec_sample_sequencer.sv
// tb/tb_codec_sample_sequencer.sv - self-checking bench for codec_sample_sequencer
module tb_codec_sample_sequencer;

  localparam int DW   = 24;
  localparam int CW   = 4;
  localparam int TO   = 8;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          bypass;
  logic          read_ready;
  logic [DW-1:0] readdata_left, readdata_right;
  logic          read;
  logic          write_ready;
  logic          write;
  logic [DW-1:0] writedata_left, writedata_right;
  logic          fx_valid;
  logic          fx_ready;
  logic [DW-1:0] fx_left, fx_right;
  logic          fx_out_valid;
  logic          fx_out_ready;
  logic [DW-1:0] fx_out_left, fx_out_right;
  logic [CW-1:0] sample_count, timeout_count;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_sc   = 0;
  int exp_tc   = 0;

  always #5 clk = ~clk;

  codec_sample_sequencer #(.DATA_W(DW), .CNT_W(CW), .FX_TIMEOUT(TO)) dut (
    .CLOCK_50        (clk),
    .reset_n         (reset_n),
    .bypass          (bypass),
    .read_ready      (read_ready),
    .readdata_left   (readdata_left),
    .readdata_right  (readdata_right),
    .read            (read),
    .write_ready     (write_ready),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .fx_valid        (fx_valid),
    .fx_ready        (fx_ready),
    .fx_left         (fx_left),
    .fx_right        (fx_right),
    .fx_out_valid    (fx_out_valid),
    .fx_out_ready    (fx_out_ready),
    .fx_out_left     (fx_out_left),
    .fx_out_right    (fx_out_right),
    .sample_count    (sample_count),
    .timeout_count   (timeout_count),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts();
    check("sample_count", 64'(sample_count), 64'(exp_sc));
    check("timeout_count", 64'(timeout_count), 64'(exp_tc));
  endtask

  // One full transaction. Cycle 0 is the capture cycle. d = cycles after entering
  // FX_SEND before fx_ready, e = cycles in FX_WAIT before fx_out_valid,
  // w = cycles in WRITE before write_ready.
  task automatic run_txn(input bit byp, input logic [DW-1:0] l, input logic [DW-1:0] r,
                         input int d, input int e, input int w, input bit rr_hold);
    bit            to;
    int            t_wr, t_write, fx_last;
    logic [DW-1:0] el, er;
    to      = !byp && (d >= TO);
    t_wr    = byp ? 1 : (to ? TO + 1 : 3 + d + e);
    t_write = t_wr + w;
    fx_last = to ? TO : 1 + d;
    el      = (byp || to) ? l : l + 1'b1;
    er      = (byp || to) ? r : r + 1'b1;
    for (int c = 0; c <= t_write; c++) begin
      bypass         = (c == 0) ? byp : 1'($urandom);
      read_ready     = (c == 0) || rr_hold;
      readdata_left  = l;
      readdata_right = r;
      if (byp)     fx_ready = 1'($urandom);
      else if (to) fx_ready = (c > TO) ? 1'($urandom) : 1'b0;
      else         fx_ready = (c == 1 + d);
      if (byp || to) begin
        fx_out_valid = 1'($urandom);
        fx_out_left  = DW'($urandom);
        fx_out_right = DW'($urandom);
      end else if (c == 2 + d + e) begin
        fx_out_valid = 1'b1;
        fx_out_left  = l + 1'b1;
        fx_out_right = r + 1'b1;
      end else begin
        fx_out_valid = 1'b0;
        fx_out_left  = DW'($urandom);
        fx_out_right = DW'($urandom);
      end
      write_ready = (c >= t_wr) ? (c == t_write) : 1'($urandom);
      @(negedge clk);
      check("read", 64'(read), 64'(c == 0));
      check("busy", 64'(busy), 64'(c != 0));
      check("fx_valid", 64'(fx_valid), 64'(!byp && c >= 1 && c <= fx_last));
      check("fx_out_ready", 64'(fx_out_ready), 64'(!byp && !to && c >= 2 + d && c <= 2 + d + e));
      check("write", 64'(write), 64'(c == t_write));
      if (!byp && c >= 1 && c <= fx_last) begin
        check("fx_left", 64'(fx_left), 64'(l));
        check("fx_right", 64'(fx_right), 64'(r));
      end
      if (c >= t_wr) begin
        check("writedata_left", 64'(writedata_left), 64'(el));
        check("writedata_right", 64'(writedata_right), 64'(er));
      end
      next_cycle();
    end
    read_ready = 1'b0;
    if (exp_sc < CMAX) exp_sc++;
    if (to && exp_tc < CMAX) exp_tc++;
    check_counts();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_read"}, 64'(read), 64'd0);
    check({tag, "_write"}, 64'(write), 64'd0);
    check({tag, "_fx_valid"}, 64'(fx_valid), 64'd0);
    check({tag, "_fx_out_ready"}, 64'(fx_out_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_wd"}, 64'({writedata_left, writedata_right}), 64'd0);
    check({tag, "_fx_lr"}, 64'({fx_left, fx_right}), 64'd0);
    check({tag, "_counts"}, 64'({sample_count, timeout_count}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    bypass         = 1'b0;
    read_ready     = 1'b0;
    readdata_left  = '0;
    readdata_right = '0;
    write_ready    = 1'b0;
    fx_ready       = 1'b0;
    fx_out_valid   = 1'b0;
    fx_out_left    = '0;
    fx_out_right   = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_reset_state("reset");
    next_cycle();
    reset_n = 1'b1;

    // Bypass: read at T, write at T+1.
    run_txn(1'b1, 24'h123456, 24'hABCDEF, 0, 0, 0, 1'b0);
    // Effect path with effect returning L+1/R+1.
    run_txn(1'b0, 24'h123456, 24'hABCDEF, 1, 1, 0, 1'b0);
    // Minimum effect latency: write at T+3.
    run_txn(1'b0, 24'h000001, 24'hFFFFFF, 0, 0, 0, 1'b0);
    // fx_ready on the final timer cycle still wins.
    run_txn(1'b0, 24'h55AA55, 24'hAA55AA, TO - 1, 2, 0, 1'b0);
    // Timeout: dry sample written.
    run_txn(1'b0, 24'h0F0F0F, 24'hF0F0F0, TO, 0, 0, 1'b0);
    // Codec stalls 50 cycles in WRITE while read_ready stays high.
    run_txn(1'b1, 24'h777777, 24'h888888, 0, 0, 50, 1'b1);
    run_txn(1'b0, 24'h246802, 24'h135791, 2, 3, 50, 1'b1);

    // Reset during FX_WAIT.
    bypass         = 1'b0;
    read_ready     = 1'b1;
    readdata_left  = 24'hDEAD01;
    readdata_right = 24'hBEEF02;
    next_cycle();
    read_ready = 1'b0;
    fx_ready   = 1'b1;
    next_cycle();
    fx_ready = 1'b0;
    @(negedge clk);
    check("pre_reset_fx_out_ready", 64'(fx_out_ready), 64'd1);
    next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n      = 1'b1;
    fx_out_valid = 1'b1;
    fx_out_left  = 24'h111111;
    fx_out_right = 24'h222222;
    write_ready  = 1'b1;
    exp_sc = 0;
    exp_tc = 0;
    @(negedge clk);
    check_reset_state("midreset");
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      check("post_reset_write", 64'(write), 64'd0);
      check("post_reset_busy", 64'(busy), 64'd0);
      check("post_reset_wd", 64'({writedata_left, writedata_right}), 64'd0);
    end
    next_cycle();
    fx_out_valid = 1'b0;

    // Counter saturation.
    for (int i = 0; i < 20; i++) begin
      run_txn(1'b1, DW'($urandom), DW'($urandom), 0, 0, $urandom_range(0, 2), 1'($urandom));
    end
    check("sample_count_saturated", 64'(sample_count), 64'hF);

    // Random mix.
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(0, 3) == 0), DW'($urandom), DW'($urandom),
              $urandom_range(0, TO + 2), $urandom_range(0, 4), $urandom_range(0, 4),
              1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_codec_sample_sequencer
